leaf_element_driver: RTL and testbench

LEAF_ELEMENT_DRIVER -- requirements
Module: leaf_element_driver

---
 rtl/lib_switchblock_pkg.sv | 16 +
 rtl/leaf_element_driver_leaf_decode.sv | 23 ++
 rtl/leaf_element_driver.sv | 162 ++++++++++++++++
 tb/tb_leaf_element_driver.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/lib_switchblock_pkg.sv
// Shared widths and FSM encoding for the switching-tree leaf driver.
package lib_switchblock_pkg;

  localparam int INPUT_WIDTH = 4;
  localparam int N_LEAF      = 8;
  localparam int SUM_WIDTH   = INPUT_WIDTH + 3;
  localparam int USAGE_WIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_CHECK  = 2'd2,
    ST_FAULT  = 2'd3
  } drv_state_t;

endpackage

// File: rtl/leaf_element_driver_leaf_decode.sv
// Single leaf decode: clamp a signed leaf code to {-1,0,+1}, drive p/n enables, flag out-of-range codes.
module leaf_decode
  import lib_switchblock_pkg::*;
(
  input  logic [INPUT_WIDTH-1:0] leaf,
  output logic                   elem_p,
  output logic                   elem_n,
  output logic                   out_of_range
);

  localparam logic signed [INPUT_WIDTH-1:0] LEAF_POS = INPUT_WIDTH'(1);
  localparam logic signed [INPUT_WIDTH-1:0] LEAF_NEG = -LEAF_POS;

  logic signed [INPUT_WIDTH-1:0] code;

  assign code = $signed(leaf);

  // Sign decides the element; magnitudes beyond one simply clamp to the same element.
  assign elem_n       = code[INPUT_WIDTH-1];
  assign elem_p       = !code[INPUT_WIDTH-1] && (code != '0);
  assign out_of_range = (code > LEAF_POS) || (code < LEAF_NEG);

endmodule

// File: rtl/leaf_element_driver.sv
// Leaf element driver: decodes leaf codes to unit-element enables and checks leaf sums against the delayed reference.
// Optional per-element usage counters are built when ELEM_USAGE_CNT_EN is defined.
module leaf_element_driver
  import lib_switchblock_pkg::*;
#(
  parameter int TREE_LATENCY = 3,
  parameter int ERR_LIMIT    = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          valid_i,
  input  logic [INPUT_WIDTH-1:0]        x_ref_i,
  input  logic [N_LEAF*INPUT_WIDTH-1:0] x_leaf_i,
  input  logic                          clear_i,
  input  logic [2:0]                    usage_sel_i,
  output logic                          valid_o,
  output logic [N_LEAF-1:0]             elem_p_o,
  output logic [N_LEAF-1:0]             elem_n_o,
  output logic                          range_err_o,
  output logic                          sum_err_o,
  output logic [15:0]                   err_cnt_o,
  output logic [1:0]                    state_o,
  output logic [USAGE_WIDTH-1:0]        usage_cnt_o
);

  localparam int WARM_W   = $clog2(TREE_LATENCY + 1);
  localparam int CONSEC_W = $clog2(ERR_LIMIT + 1);

  drv_state_t state, state_next;

  logic [N_LEAF-1:0] dec_p, dec_n, dec_rng;
  logic [N_LEAF-1:0] p_q, n_q;
  logic              valid_q, rng_q;

  logic signed [INPUT_WIDTH-1:0] ref_dly [TREE_LATENCY];
  logic signed [SUM_WIDTH-1:0]   leaf_sum, ref_wide;
  logic                          mismatch;

  logic [WARM_W-1:0]   warm_cnt;
  logic [CONSEC_W-1:0] consec_cnt;
  logic [15:0]         err_cnt;
  logic                sum_err;

  for (genvar k = 0; k < N_LEAF; k++) begin : g_leaf
    leaf_decode u_dec (
      .leaf         (x_leaf_i[k*INPUT_WIDTH +: INPUT_WIDTH]),
      .elem_p       (dec_p[k]),
      .elem_n       (dec_n[k]),
      .out_of_range (dec_rng[k])
    );
  end

  // Sum of raw (unclamped) codes, so an out-of-range leaf also shows up as a mismatch.
  always_comb begin
    leaf_sum = '0;
    for (int k = 0; k < N_LEAF; k++) begin
      leaf_sum = leaf_sum + SUM_WIDTH'($signed(x_leaf_i[k*INPUT_WIDTH +: INPUT_WIDTH]));
    end
  end

  assign ref_wide = SUM_WIDTH'(ref_dly[TREE_LATENCY-1]);
  assign mismatch = valid_i && (state == ST_CHECK) && (leaf_sum != ref_wide);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < TREE_LATENCY; i++) ref_dly[i] <= '0;
    end else begin
      ref_dly[0] <= $signed(x_ref_i);
      for (int i = 1; i < TREE_LATENCY; i++) ref_dly[i] <= ref_dly[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) state <= ST_IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (valid_i) state_next = ST_WARMUP;
      ST_WARMUP: if (warm_cnt == '0) state_next = ST_CHECK;
      ST_CHECK:  if (mismatch && (consec_cnt >= CONSEC_W'(ERR_LIMIT - 1))) state_next = ST_FAULT;
      ST_FAULT:  state_next = ST_FAULT;
      default:   state_next = ST_IDLE;
    endcase
    if (clear_i) state_next = ST_IDLE;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      warm_cnt <= '0;
    end else if (state == ST_IDLE) begin
      warm_cnt <= WARM_W'(TREE_LATENCY - 1);
    end else if ((state == ST_WARMUP) && (warm_cnt != '0)) begin
      warm_cnt <= warm_cnt - 1'b1;
    end
  end

  // Clear has priority over a mismatch in the same cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      err_cnt    <= '0;
      sum_err    <= 1'b0;
      consec_cnt <= '0;
    end else if (mismatch) begin
      if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
      sum_err <= 1'b1;
      if (consec_cnt != CONSEC_W'(ERR_LIMIT)) consec_cnt <= consec_cnt + 1'b1;
    end else if (valid_i && (state == ST_CHECK)) begin
      consec_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_q <= 1'b0;
      p_q     <= '0;
      n_q     <= '0;
      rng_q   <= 1'b0;
    end else begin
      valid_q <= valid_i;
      p_q     <= valid_i ? dec_p : '0;
      n_q     <= valid_i ? dec_n : '0;
      rng_q   <= valid_i && (|dec_rng);
    end
  end

  assign valid_o     = (state == ST_FAULT) ? 1'b0 : valid_q;
  assign elem_p_o    = (state == ST_FAULT) ? '0 : p_q;
  assign elem_n_o    = (state == ST_FAULT) ? '0 : n_q;
  assign range_err_o = rng_q;
  assign sum_err_o   = sum_err;
  assign err_cnt_o   = err_cnt;
  assign state_o     = state;

`ifdef ELEM_USAGE_CNT_EN
  logic [USAGE_WIDTH-1:0] usage_cnt [N_LEAF];
  logic [USAGE_WIDTH-1:0] usage_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      for (int k = 0; k < N_LEAF; k++) usage_cnt[k] <= '0;
      usage_q <= '0;
    end else begin
      for (int k = 0; k < N_LEAF; k++) begin
        if (valid_o && (elem_p_o[k] || elem_n_o[k]) && (usage_cnt[k] != '1))
          usage_cnt[k] <= usage_cnt[k] + 1'b1;
      end
      usage_q <= usage_cnt[usage_sel_i];
    end
  end

  assign usage_cnt_o = usage_q;
`else
  logic unused_sel;

  assign unused_sel  = ^usage_sel_i;
  assign usage_cnt_o = '0;
`endif

endmodule

// File: tb/tb_leaf_element_driver.sv
// Directed self-checking bench for leaf_element_driver (default TREE_LATENCY=3, ERR_LIMIT=4, 4-bit leaves).
module tb_leaf_element_driver;

  logic        clk_i = 1'b0;
  logic        reset_i, valid_i, clear_i;
  logic [3:0]  x_ref_i;
  logic [31:0] x_leaf_i;
  logic [2:0]  usage_sel_i;
  logic        valid_o, range_err_o, sum_err_o;
  logic [7:0]  elem_p_o, elem_n_o;
  logic [15:0] err_cnt_o;
  logic [1:0]  state_o;
  logic [11:0] usage_cnt_o;

  int checks = 0;
  int errors = 0;
  int vec [8];
  logic [11:0] usage_exp;

  leaf_element_driver dut (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .valid_i     (valid_i),
    .x_ref_i     (x_ref_i),
    .x_leaf_i    (x_leaf_i),
    .clear_i     (clear_i),
    .usage_sel_i (usage_sel_i),
    .valid_o     (valid_o),
    .elem_p_o    (elem_p_o),
    .elem_n_o    (elem_n_o),
    .range_err_o (range_err_o),
    .sum_err_o   (sum_err_o),
    .err_cnt_o   (err_cnt_o),
    .state_o     (state_o),
    .usage_cnt_o (usage_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input int lv [8]);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < 8; k++) r[k*4 +: 4] = 4'(lv[k]);
    return r;
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    reset_i = 1'b1; valid_i = 1'b0; clear_i = 1'b0;
    x_ref_i = '0; x_leaf_i = '0; usage_sel_i = '0;
    step(); step();
    reset_i = 1'b0;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_valid", 32'(valid_o), 0);
    chk("rst_p", 32'(elem_p_o), 0);
    chk("rst_err_cnt", 32'(err_cnt_o), 0);

    // Out-of-range leaf0 = +3 while idle (no sum check yet); first valid starts warmup.
    vec = '{3, 0, 0, 0, 0, 0, 0, 0};
    x_leaf_i = pack(vec); valid_i = 1'b1;
    step();
    chk("range_pulse", 32'(range_err_o), 1);
    chk("range_p", 32'(elem_p_o), 32'h01);
    chk("range_n", 32'(elem_n_o), 32'h00);
    chk("warmup_state", 32'(state_o), 1);
    valid_i = 1'b0; x_leaf_i = '0; x_ref_i = 4'd2;
    step();
    chk("range_pulse_end", 32'(range_err_o), 0);
    chk("idle_valid_low", 32'(valid_o), 0);
    step(); step(); step();
    chk("check_state", 32'(state_o), 2);

    // Leaf k drives bit k; list is leaf0 first, sum 2 matches delayed x_ref 2.
    vec = '{1, -1, 0, 1, 1, 0, -1, 1};
    x_leaf_i = pack(vec); valid_i = 1'b1;
    step();
    chk("decode_p", 32'(elem_p_o), 32'b1001_1001);
    chk("decode_n", 32'(elem_n_o), 32'b0100_0010);
    chk("decode_valid", 32'(valid_o), 1);
    chk("match_err_cnt", 32'(err_cnt_o), 0);
    chk("match_sum_err", 32'(sum_err_o), 0);
    vec = '{1, -1, 0, 0, 1, 1, -1, 1};
    x_leaf_i = pack(vec);
    step();
    chk("decode2_p", 32'(elem_p_o), 32'b1011_0001);
    chk("decode2_n", 32'(elem_n_o), 32'b0100_0010);
    chk("match2_err_cnt", 32'(err_cnt_o), 0);

    // Sum 3 against reference 2.
    vec = '{1, 1, 1, 0, 0, 0, 0, 0};
    x_leaf_i = pack(vec);
    step();
    chk("mis1_err_cnt", 32'(err_cnt_o), 1);
    chk("mis1_sum_err", 32'(sum_err_o), 1);

    // A match resets the run; three more mismatches stay below the limit.
    vec = '{1, 1, 0, 0, 0, 0, 0, 0};
    x_leaf_i = pack(vec);
    step();
    vec = '{1, 1, 1, 0, 0, 0, 0, 0};
    x_leaf_i = pack(vec);
    step(); step(); step();
    chk("mis4_err_cnt", 32'(err_cnt_o), 4);
    chk("below_limit_state", 32'(state_o), 2);
    chk("sticky_sum_err", 32'(sum_err_o), 1);
    valid_i = 1'b0;
    step();
    chk("gap_state", 32'(state_o), 2);
    valid_i = 1'b1;
    step();
    chk("fault_state", 32'(state_o), 3);
    chk("fault_err_cnt", 32'(err_cnt_o), 5);
    chk("fault_valid", 32'(valid_o), 0);
    chk("fault_p", 32'(elem_p_o), 0);
    vec = '{1, 1, 0, 0, 0, 0, 0, 0};
    x_leaf_i = pack(vec);
    step();
    chk("fault_hold_state", 32'(state_o), 3);
    chk("fault_hold_p", 32'(elem_p_o), 0);

    // Clear beats a simultaneous mismatch.
    vec = '{1, 1, 1, 0, 0, 0, 0, 0};
    x_leaf_i = pack(vec); clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    chk("clear_state", 32'(state_o), 0);
    chk("clear_err_cnt", 32'(err_cnt_o), 0);
    chk("clear_sum_err", 32'(sum_err_o), 0);

    // Long matching stream (sum 3) keeps element 2 active.
    valid_i = 1'b0; x_leaf_i = '0; x_ref_i = 4'd3;
    step(); step(); step();
    chk("idle_after_gap", 32'(state_o), 0);
    vec = '{1, -1, 1, 1, 1, 0, -1, 1};
    x_leaf_i = pack(vec); valid_i = 1'b1; usage_sel_i = 3'd2;
    for (int i = 0; i < 5000; i++) step();
    chk("stream_state", 32'(state_o), 2);
    chk("stream_err_cnt", 32'(err_cnt_o), 0);
`ifdef ELEM_USAGE_CNT_EN
    usage_exp = 12'd4095;
`else
    usage_exp = 12'd0;
`endif
    chk("usage_sat", 32'(usage_cnt_o), 32'(usage_exp));
    usage_sel_i = 3'd5;
    step(); step();
    chk("usage_idle_elem", 32'(usage_cnt_o), 0);

    // Mid-stream reset discards everything in flight.
    reset_i = 1'b1;
    step(); step();
    chk("mrst_state", 32'(state_o), 0);
    chk("mrst_valid", 32'(valid_o), 0);
    chk("mrst_p", 32'(elem_p_o), 0);
    chk("mrst_n", 32'(elem_n_o), 0);
    chk("mrst_usage", 32'(usage_cnt_o), 0);
    reset_i = 1'b0; valid_i = 1'b0;
    step();
    chk("post_rst_state", 32'(state_o), 0);
    chk("post_rst_range", 32'(range_err_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
